// File: rtl/ppu_pkg.sv
// Shared PPU definitions: CPU register indices, scroll-latch widths and
// the pending-action encoding used by the register interface.
package ppu_pkg;

    localparam int unsigned FV_W = 3;
    localparam int unsigned VT_W = 5;
    localparam int unsigned FH_W = 3;
    localparam int unsigned HT_W = 5;

    localparam logic [2:0] PPUCTRL   = 3'd0;
    localparam logic [2:0] PPUMASK   = 3'd1;
    localparam logic [2:0] PPUSTATUS = 3'd2;
    localparam logic [2:0] OAMADDR   = 3'd3;
    localparam logic [2:0] OAMDATA   = 3'd4;
    localparam logic [2:0] PPUSCROLL = 3'd5;
    localparam logic [2:0] PPUADDR   = 3'd6;
    localparam logic [2:0] PPUDATA   = 3'd7;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_UPD,
        ACT_VRAM_WR,
        ACT_VRAM_RD,
        ACT_OAM_WR
    } act_e;

endpackage

// File: rtl/ppu_ri_if.sv
// CPU-side bus of the PPU register interface; master is the CPU, slave the PPU.
interface ppu_ri_if;

    logic [2:0] sel_in;
    logic       ncs_in;
    logic       r_nw_in;
    logic [7:0] cpu_d_in;
    logic [7:0] cpu_d_out;

    modport master (output sel_in, output ncs_in, output r_nw_in,
                    output cpu_d_in, input cpu_d_out);
    modport slave  (input sel_in, input ncs_in, input r_nw_in,
                    input cpu_d_in, output cpu_d_out);

endinterface

// File: rtl/ppu_ri_edge.sv
// Single-signal edge detector; edge_c is high in the cycle the input differs
// from its registered previous value in the selected direction.
module ppu_ri_edge #(
    parameter bit RISE     = 1'b1,
    parameter bit PREV_RST = 1'b0
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic sig_in,
    output logic edge_c
);

    logic prev_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) prev_q <= PREV_RST;
        else        prev_q <= sig_in;
    end

    assign edge_c = RISE ? (sig_in & ~prev_q) : (~sig_in & prev_q);

endmodule

// File: rtl/ppu_ri.sv
// PPU register interface: decodes CPU accesses to $2000-$2007, holds the
// scroll/control latches and issues one-cycle strobes in the action cycle.
module ppu_ri
    import ppu_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    ppu_ri_if.slave           cpu,
    input  logic [7:0]        vram_d_in,
    input  logic              vblank_in,
    input  logic              spr_overflow_in,
    input  logic              spr0_hit_in,
    input  logic [7:0]        oam_d_in,
    output logic [FV_W-1:0]   fv_out,
    output logic [VT_W-1:0]   vt_out,
    output logic              v_out,
    output logic [FH_W-1:0]   fh_out,
    output logic [HT_W-1:0]   ht_out,
    output logic              h_out,
    output logic              s_out,
    output logic              upd_cntrs_out,
    output logic              inc_addr_out,
    output logic              inc_addr_amt_out,
    output logic              vram_wr_out,
    output logic [7:0]        vram_d_out,
    output logic              bg_en_out,
    output logic              spr_en_out,
    output logic              bg_ls_clip_out,
    output logic              spr_ls_clip_out,
    output logic              spr_h_out,
    output logic              spr_pt_sel_out,
    output logic [7:0]        oam_a_out,
    output logic [7:0]        oam_d_out,
    output logic              oam_wr_out,
    output logic              nvbl_out
);

    logic       cs_evt;
    logic       vbl_rise;
    logic       vbl_fall;
    logic       status_rd;
    logic       w_q;
    logic       nvbl_en_q;
    logic       vbl_flag_q;
    logic [7:0] rd_buf_q;
    act_e       act_q;
    act_e       act_d;

    ppu_ri_edge #(.RISE(1'b0), .PREV_RST(1'b0)) u_cs_edge (
        .clk_in(clk_in), .rst_in(rst_in), .sig_in(cpu.ncs_in), .edge_c(cs_evt));

    ppu_ri_edge #(.RISE(1'b1), .PREV_RST(1'b1)) u_vbl_rise (
        .clk_in(clk_in), .rst_in(rst_in), .sig_in(vblank_in), .edge_c(vbl_rise));

    ppu_ri_edge #(.RISE(1'b0), .PREV_RST(1'b0)) u_vbl_fall (
        .clk_in(clk_in), .rst_in(rst_in), .sig_in(vblank_in), .edge_c(vbl_fall));

    assign status_rd = cs_evt & cpu.r_nw_in & (cpu.sel_in == PPUSTATUS);

    // Action stage: the access decoded in cycle T becomes a strobe in T+1.
    always_ff @(posedge clk_in) begin
        if (rst_in) act_q <= ACT_NONE;
        else        act_q <= act_d;
    end

    always_comb begin
        act_d = ACT_NONE;
        if (cs_evt) begin
            if (cpu.r_nw_in) begin
                if (cpu.sel_in == PPUDATA) act_d = ACT_VRAM_RD;
            end else begin
                case (cpu.sel_in)
                    OAMDATA: act_d = ACT_OAM_WR;
                    PPUADDR: act_d = w_q ? ACT_UPD : ACT_NONE;
                    PPUDATA: act_d = ACT_VRAM_WR;
                    default: act_d = ACT_NONE;
                endcase
            end
        end
    end

    assign upd_cntrs_out = (act_q == ACT_UPD);
    assign vram_wr_out   = (act_q == ACT_VRAM_WR);
    assign oam_wr_out    = (act_q == ACT_OAM_WR);
    assign inc_addr_out  = (act_q == ACT_VRAM_WR) | (act_q == ACT_VRAM_RD);
    assign nvbl_out      = ~(vbl_flag_q & nvbl_en_q);

    // Register decode and latch updates.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fv_out           <= '0;
            vt_out           <= '0;
            v_out            <= 1'b0;
            fh_out           <= '0;
            ht_out           <= '0;
            h_out            <= 1'b0;
            s_out            <= 1'b0;
            inc_addr_amt_out <= 1'b0;
            spr_pt_sel_out   <= 1'b0;
            spr_h_out        <= 1'b0;
            nvbl_en_q        <= 1'b0;
            bg_en_out        <= 1'b0;
            spr_en_out       <= 1'b0;
            bg_ls_clip_out   <= 1'b0;
            spr_ls_clip_out  <= 1'b0;
            oam_a_out        <= '0;
            oam_d_out        <= '0;
            vram_d_out       <= '0;
            w_q              <= 1'b0;
            rd_buf_q         <= '0;
            vbl_flag_q       <= 1'b0;
        end else begin
            if (act_q == ACT_VRAM_RD) rd_buf_q <= vram_d_in;
            if (act_q == ACT_OAM_WR)  oam_a_out <= oam_a_out + 8'd1;

            // A set edge beats a same-cycle status read.
            if (vbl_rise)                    vbl_flag_q <= 1'b1;
            else if (vbl_fall || status_rd)  vbl_flag_q <= 1'b0;

            if (status_rd) w_q <= 1'b0;

            if (cs_evt && !cpu.r_nw_in) begin
                case (cpu.sel_in)
                    PPUCTRL: begin
                        {v_out, h_out}   <= cpu.cpu_d_in[1:0];
                        inc_addr_amt_out <= cpu.cpu_d_in[2];
                        spr_pt_sel_out   <= cpu.cpu_d_in[3];
                        s_out            <= cpu.cpu_d_in[4];
                        spr_h_out        <= cpu.cpu_d_in[5];
                        nvbl_en_q        <= cpu.cpu_d_in[7];
                    end
                    PPUMASK: begin
                        bg_ls_clip_out  <= ~cpu.cpu_d_in[1];
                        spr_ls_clip_out <= ~cpu.cpu_d_in[2];
                        bg_en_out       <= cpu.cpu_d_in[3];
                        spr_en_out      <= cpu.cpu_d_in[4];
                    end
                    OAMADDR: oam_a_out <= cpu.cpu_d_in;
                    OAMDATA: oam_d_out <= cpu.cpu_d_in;
                    PPUSCROLL: begin
                        if (w_q) begin
                            fv_out <= cpu.cpu_d_in[2:0];
                            vt_out <= cpu.cpu_d_in[7:3];
                        end else begin
                            fh_out <= cpu.cpu_d_in[2:0];
                            ht_out <= cpu.cpu_d_in[7:3];
                        end
                        w_q <= ~w_q;
                    end
                    PPUADDR: begin
                        if (w_q) begin
                            vt_out[2:0] <= cpu.cpu_d_in[7:5];
                            ht_out      <= cpu.cpu_d_in[4:0];
                        end else begin
                            fv_out      <= {1'b0, cpu.cpu_d_in[5:4]};
                            v_out       <= cpu.cpu_d_in[3];
                            h_out       <= cpu.cpu_d_in[2];
                            vt_out[4:3] <= cpu.cpu_d_in[1:0];
                        end
                        w_q <= ~w_q;
                    end
                    PPUDATA: vram_d_out <= cpu.cpu_d_in;
                    default: ;
                endcase
            end
        end
    end

    // Read data is a combinational view of current state while selected.
    always_comb begin
        cpu.cpu_d_out = 8'h00;
        if (!rst_in && !cpu.ncs_in && cpu.r_nw_in) begin
            case (cpu.sel_in)
                PPUSTATUS: cpu.cpu_d_out = {vbl_flag_q, spr0_hit_in, spr_overflow_in, 5'b0};
                OAMDATA:   cpu.cpu_d_out = oam_d_in;
                PPUDATA:   cpu.cpu_d_out = rd_buf_q;
                default:   cpu.cpu_d_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_ri.sv
// Self-checking bench for ppu_ri: directed scenarios followed by random
// register traffic, compared against an arithmetic model of the registers.
module tb_ppu_ri;
    import ppu_pkg::*;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [7:0] vram_d_in, oam_d_in;
    logic       vblank_in, spr_overflow_in, spr0_hit_in;
    logic [2:0] fv_out, fh_out;
    logic [4:0] vt_out, ht_out;
    logic       v_out, h_out, s_out, upd_cntrs_out, inc_addr_out, inc_addr_amt_out;
    logic       vram_wr_out, bg_en_out, spr_en_out, bg_ls_clip_out, spr_ls_clip_out;
    logic       spr_h_out, spr_pt_sel_out, oam_wr_out, nvbl_out;
    logic [7:0] vram_d_out, oam_a_out, oam_d_out;

    ppu_ri_if bus ();

    ppu_ri dut (
        .clk_in(clk_in), .rst_in(rst_in), .cpu(bus),
        .vram_d_in(vram_d_in), .vblank_in(vblank_in),
        .spr_overflow_in(spr_overflow_in), .spr0_hit_in(spr0_hit_in),
        .oam_d_in(oam_d_in),
        .fv_out(fv_out), .vt_out(vt_out), .v_out(v_out), .fh_out(fh_out),
        .ht_out(ht_out), .h_out(h_out), .s_out(s_out),
        .upd_cntrs_out(upd_cntrs_out), .inc_addr_out(inc_addr_out),
        .inc_addr_amt_out(inc_addr_amt_out), .vram_wr_out(vram_wr_out),
        .vram_d_out(vram_d_out), .bg_en_out(bg_en_out), .spr_en_out(spr_en_out),
        .bg_ls_clip_out(bg_ls_clip_out), .spr_ls_clip_out(spr_ls_clip_out),
        .spr_h_out(spr_h_out), .spr_pt_sel_out(spr_pt_sel_out),
        .oam_a_out(oam_a_out), .oam_d_out(oam_d_out), .oam_wr_out(oam_wr_out),
        .nvbl_out(nvbl_out));

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Register model kept as plain integers.
    int m_fv, m_vt, m_v, m_fh, m_ht, m_h;
    int m_s, m_amt, m_pt, m_sh, m_nmi_en, m_bg, m_sp, m_bgc, m_spc;
    int m_oam_a, m_oam_d, m_vd, m_buf, m_w, m_flag;
    int last_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fv = 0; m_vt = 0; m_v = 0; m_fh = 0; m_ht = 0; m_h = 0;
        m_s = 0; m_amt = 0; m_pt = 0; m_sh = 0; m_nmi_en = 0;
        m_bg = 0; m_sp = 0; m_bgc = 0; m_spc = 0;
        m_oam_a = 0; m_oam_d = 0; m_vd = 0; m_buf = 0; m_w = 0; m_flag = 0;
    endtask

    function automatic logic [3:0] strobes();
        return {upd_cntrs_out, inc_addr_out, vram_wr_out, oam_wr_out};
    endfunction

    task automatic check_state(input string where);
        chk({where, "_scroll"}, 32'({fv_out, vt_out, v_out, fh_out, ht_out, h_out}),
            (m_fv << 15) | (m_vt << 10) | (m_v << 9) | (m_fh << 6) | (m_ht << 1) | m_h);
        chk({where, "_ctrl"}, 32'({s_out, inc_addr_amt_out, spr_pt_sel_out, spr_h_out,
                                   bg_en_out, spr_en_out, bg_ls_clip_out, spr_ls_clip_out}),
            (m_s << 7) | (m_amt << 6) | (m_pt << 5) | (m_sh << 4) |
            (m_bg << 3) | (m_sp << 2) | (m_bgc << 1) | m_spc);
        chk({where, "_oam_a"}, 32'(oam_a_out), m_oam_a);
        chk({where, "_oam_d"}, 32'(oam_d_out), m_oam_d);
        chk({where, "_vram_d"}, 32'(vram_d_out), m_vd);
        chk({where, "_nvbl"}, 32'(nvbl_out), (m_flag != 0 && m_nmi_en != 0) ? 0 : 1);
    endtask

    // One CPU access: ncs low for one cycle (T), high in the action cycle.
    task automatic access(input logic [2:0] s, input logic rnw, input logic [7:0] d, input bit rise);
        int di;
        int exp_rd;
        int exp_strb;
        di = int'(d);
        @(posedge clk_in); #1;
        bus.sel_in = s; bus.r_nw_in = rnw; bus.cpu_d_in = d; bus.ncs_in = 1'b0;
        if (rise) vblank_in = 1'b1;
        exp_rd = 0;
        if (rnw) begin
            if (s == PPUSTATUS) exp_rd = (m_flag << 7) | (int'(spr0_hit_in) << 6) | (int'(spr_overflow_in) << 5);
            if (s == OAMDATA)   exp_rd = int'(oam_d_in);
            if (s == PPUDATA)   exp_rd = m_buf;
        end
        @(negedge clk_in);
        last_rd = int'(bus.cpu_d_out);
        chk("rd_data", 32'(bus.cpu_d_out), exp_rd);
        chk("strobe_in_T", 32'(strobes()), 0);

        exp_strb = 0;
        if (rise) m_flag = 1;
        else if (rnw && s == PPUSTATUS) m_flag = 0;
        if (rnw) begin
            if (s == PPUSTATUS) m_w = 0;
            if (s == PPUDATA) exp_strb = 4;
        end else begin
            case (s)
                3'd0: begin
                    m_h = di % 2; m_v = (di / 2) % 2; m_amt = (di / 4) % 2;
                    m_pt = (di / 8) % 2; m_s = (di / 16) % 2; m_sh = (di / 32) % 2;
                    m_nmi_en = di / 128;
                end
                3'd1: begin
                    m_bgc = 1 - (di / 2) % 2; m_spc = 1 - (di / 4) % 2;
                    m_bg = (di / 8) % 2; m_sp = (di / 16) % 2;
                end
                3'd3: m_oam_a = di;
                3'd4: begin m_oam_d = di; exp_strb = 1; end
                3'd5: begin
                    if (m_w != 0) begin m_fv = di % 8; m_vt = di / 8; end
                    else          begin m_fh = di % 8; m_ht = di / 8; end
                    m_w = 1 - m_w;
                end
                3'd6: begin
                    if (m_w != 0) begin
                        m_vt = (m_vt / 8) * 8 + di / 32; m_ht = di % 32; exp_strb = 8;
                    end else begin
                        m_fv = (di / 16) % 4; m_v = (di / 8) % 2; m_h = (di / 4) % 2;
                        m_vt = (di % 4) * 8 + (m_vt % 8);
                    end
                    m_w = 1 - m_w;
                end
                3'd7: begin m_vd = di; exp_strb = 6; end
                default: ;
            endcase
        end

        @(posedge clk_in); #1;
        bus.ncs_in = 1'b1;
        @(negedge clk_in);
        chk("strobe_action", 32'(strobes()), exp_strb);
        chk("rd_idle", 32'(bus.cpu_d_out), 0);
        check_state("acc");
        if (exp_strb == 1) m_oam_a = (m_oam_a + 1) % 256;
        if (rnw && s == PPUDATA) m_buf = int'(vram_d_in);
    endtask

    task automatic vbl_fall();
        @(posedge clk_in); #1;
        vblank_in = 1'b0;
        @(posedge clk_in);
        m_flag = 0;
    endtask

    initial begin
        int cnt;
        bit rise;
        bus.ncs_in = 1'b1; bus.sel_in = '0; bus.r_nw_in = 1'b1; bus.cpu_d_in = '0;
        vblank_in = 1'b0; spr0_hit_in = 1'b0; spr_overflow_in = 1'b0;
        vram_d_in = '0; oam_d_in = '0; rst_in = 1'b1;
        model_reset();
        last_rd = 0;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;

        // Reset state while idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            chk("idle_strobe", 32'(strobes()), 0);
            chk("idle_rd", 32'(bus.cpu_d_out), 0);
        end
        check_state("reset");

        // $2006 pair loads scroll latches and pulses upd_cntrs
        access(PPUADDR, 1'b0, 8'h21, 1'b0);
        access(PPUADDR, 1'b0, 8'h08, 1'b0);
        chk("ppuaddr_latches", 32'({fv_out, vt_out, v_out, fh_out, ht_out, h_out}),
            32'({3'd2, 5'd8, 1'b0, 3'd0, 5'd8, 1'b0}));

        // Increment-by-32 then a VRAM write
        access(PPUCTRL, 1'b0, 8'h04, 1'b0);
        access(PPUDATA, 1'b0, 8'hAB, 1'b0);
        chk("vram_wr_data", 32'(vram_d_out), 32'(8'hAB));

        // Buffered VRAM reads
        vram_d_in = 8'h5A;
        access(PPUDATA, 1'b1, 8'h00, 1'b0);
        chk("buf_first", 32'(last_rd), 0);
        access(PPUDATA, 1'b1, 8'h00, 1'b0);
        chk("buf_second", 32'(last_rd), 32'(8'h5A));

        // Status read resets the write toggle
        access(PPUSCROLL, 1'b0, 8'h7D, 1'b0);
        access(PPUSTATUS, 1'b1, 8'h00, 1'b0);
        access(PPUSCROLL, 1'b0, 8'h3B, 1'b0);
        chk("toggle_ht", 32'(ht_out), 7);
        chk("toggle_fh", 32'(fh_out), 3);

        // NMI on vblank, cleared by status read
        access(PPUCTRL, 1'b0, 8'h80, 1'b0);
        @(posedge clk_in); #1 vblank_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        m_flag = 1;
        chk("nmi_asserted", 32'(nvbl_out), 0);
        access(PPUSTATUS, 1'b1, 8'h00, 1'b0);
        chk("status_vbl", 32'(last_rd), 32'(8'h80));
        chk("nmi_released", 32'(nvbl_out), 1);
        vbl_fall();

        // Set edge and status read in the same cycle: set wins
        access(PPUSTATUS, 1'b1, 8'h00, 1'b1);
        chk("race_rd", 32'(last_rd), 0);
        chk("race_nmi", 32'(nvbl_out), 0);
        vbl_fall();
        @(negedge clk_in);
        chk("fall_clears", 32'(nvbl_out), 1);

        // Long chip-select produces a single action
        @(posedge clk_in); #1;
        bus.sel_in = OAMDATA; bus.r_nw_in = 1'b0; bus.cpu_d_in = 8'h3C; bus.ncs_in = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            if (oam_wr_out) cnt++;
            @(posedge clk_in); #1;
        end
        bus.ncs_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            if (oam_wr_out) cnt++;
        end
        chk("long_cs_one_pulse", 32'(cnt), 1);
        m_oam_d = 8'h3C;
        m_oam_a = (m_oam_a + 1) % 256;
        check_state("long_cs");

        // Reset during the event cycle drops the pending action
        @(posedge clk_in); #1;
        bus.sel_in = PPUDATA; bus.r_nw_in = 1'b0; bus.cpu_d_in = 8'h55; bus.ncs_in = 1'b0;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0; bus.ncs_in = 1'b1;
        @(negedge clk_in);
        chk("rst_mid_strobe", 32'(strobes()), 0);
        model_reset();
        check_state("rst_mid");

        // Random register traffic
        for (int i = 0; i < 120; i++) begin
            @(posedge clk_in); #1;
            spr0_hit_in     = 1'($urandom_range(0, 1));
            spr_overflow_in = 1'($urandom_range(0, 1));
            vram_d_in       = 8'($urandom);
            oam_d_in        = 8'($urandom);
            if (vblank_in && $urandom_range(0, 2) == 0) vbl_fall();
            rise = !vblank_in && ($urandom_range(0, 5) == 0);
            access(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom), rise);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
